ahb_lite_slave_mem: RTL
=======================

// Module: ahb_lite_slave_mem
// PURPOSE
//  AHB-Lite responder: word-organised memory slave, the other end of the bus driven by the master VIP.
//  Decodes address phases, inserts programmable wait states, and performs byte/half/word writes and reads.
//  Returns the two-cycle ERROR response for illegal accesses.
//  Serves as the DUT-side target that closes the loop for master VIP regressions.
// PARAMETERS
//  ADDR_WIDTH   32    HADDR width
//  DATA_WIDTH   32    HWDATA/HRDATA width; only 32 supported
//  MEM_DEPTH    1024  number of 32-bit words; legal byte range 0 .. 4*MEM_DEPTH-1
//  WAIT_STATES  0     HREADYOUT-low cycles inserted per NONSEQ/SEQ data phase (0..15)
// PORTS
//  HCLK       in   1           bus clock, all state on rising edge
//  HRESETn    in   1           asynchronous active-low reset
//  HSEL       in   1           slave select (address phase)
//  HADDR      in   ADDR_WIDTH  byte address
//  HWRITE     in   1           1=write, 0=read
//  HSIZE      in   3           size_type; BYTE/HALF_WORD/WORD legal
//  HBURST     in   3           burst_type; informational only, not checked
//  HPROT      in   4           ignored
//  HTRANS     in   2           trans_type IDLE/BUSY/NONSEQ/SEQ
//  HMASTLOCK  in   1           ignored
//  HREADY     in   1           bus-level ready (previous transfer complete)
//  HWDATA     in   DATA_WIDTH  write data (data phase)
//  HRDATA     out  DATA_WIDTH  read data, valid when HREADYOUT=1 in read data phase, else 0
//  HREADYOUT  out  1           slave ready
//  HRESP      out  1           0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset (async on HRESETn=0): HREADYOUT=1, HRESP=0, HRDATA=0, FSM->ST_IDLE, pending write dropped.
//  Memory contents are not reset.
//  Address-phase capture when HSEL & HREADY & HTRANS in {NONSEQ,SEQ}: register addr, write, size, and err flag.
//  Capture sets wait counter = WAIT_STATES.
//  IDLE/BUSY or HSEL=0 with HREADY=1: no capture; next data phase is zero-wait OKAY.
//  err = addr >= 4*MEM_DEPTH, OR size > WORD, OR misaligned (HALF_WORD with addr[0]=1, WORD with addr[1:0]!=0).
//  FSM ST_IDLE:
//    legal capture -> ST_WAIT if WAIT_STATES>0, else ST_DATA.
//    err capture -> ST_ERR1.
//  FSM ST_WAIT: HREADYOUT=0, HRESP=0, counter decrements; at counter==1 -> ST_DATA.
//  FSM ST_DATA: HREADYOUT=1, HRESP=0; transfer completes.
//    Write: HWDATA lanes merged into mem[addr>>2] at this edge.
//    Read: HRDATA = mem[addr>>2] (all 4 lanes driven).
//    New capture same cycle -> next state per rules above; else ST_IDLE.
//  FSM ST_ERR1: HREADYOUT=0, HRESP=1 -> ST_ERR2; no memory access.
//  FSM ST_ERR2: HREADYOUT=1, HRESP=1; capture allowed (master may cancel with IDLE).
//  Latency: data phase = WAIT_STATES+1 cycles OKAY; exactly 2 cycles ERROR (WAIT_STATES not applied).
//  Lane strobes: BYTE -> 1<<addr[1:0]; HALF_WORD -> 4'b0011<<addr[1:0]; WORD -> 4'b1111.
//  Back-to-back write A then read A: read returns the new data (write commits before read data phase).
//  BUSY during burst: zero-wait OKAY, no memory access, burst beat count unaffected.
// STRUCTURE
//  ahb_pkg additions: typedef enum logic {OKAY,ERROR} resp_type; typedef enum {ST_IDLE,ST_WAIT,ST_DATA,ST_ERR1,ST_ERR2} slv_state.
//  Reuse existing trans_type and size_type from ahb_pkg.
//  Sub-module ahb_slv_lane_dec: combinational HSIZE+HADDR[1:0] -> 4-bit byte strobe + misalign flag.
// TESTING
//  1. WAIT_STATES=0: write WORD 0xDEADBEEF @0x10, read @0x10 -> HRDATA=0xDEADBEEF; each phase HREADYOUT=1, HRESP=0.
//  2. WAIT_STATES=2: NONSEQ read -> HREADYOUT 0,0,1; HRESP=0 throughout.
//  3. Byte writes 0x11@0x20, 0x22@0x21, half 0x4433@0x22 -> word read @0x20 = 0x44332211.
//  4. Read @4*MEM_DEPTH, or WORD @0x02 -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1; memory unchanged.
//  5. INCR4 WORD writes @0x40 with BUSY between beats 2 and 3 -> BUSY gets zero-wait OKAY, 4 words written.
//  6. Assert HRESETn=0 in ST_WAIT of a write -> HREADYOUT=1, HRESP=0 immediately; target word unchanged.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings plus the memory slave's response and FSM state types.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } trans_type;

  typedef enum logic [2:0] {
    BYTE      = 3'b000,
    HALF_WORD = 3'b001,
    WORD      = 3'b010
  } size_type;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } resp_type;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state;

  localparam int unsigned MAX_WAIT_STATES = 15;

endpackage

// File: rtl/ahb_slv_lane_dec.sv
// Byte-lane decoder: transfer size and low address bits to a 4-lane write strobe,
// flagging half-words and words that straddle their natural alignment.
module ahb_slv_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       misalign
);

  always_comb begin
    strb     = 4'b0000;
    misalign = 1'b0;
    case (hsize)
      BYTE: begin
        strb = 4'b0001 << addr_lo;
      end
      HALF_WORD: begin
        strb     = 4'b0011 << addr_lo;
        misalign = addr_lo[0];
      end
      WORD: begin
        strb     = 4'b1111;
        misalign = |addr_lo;
      end
      default: begin
        strb     = 4'b0000;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite word-organised memory slave with programmable wait states and the
// two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahb_lite_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int                  IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);
  localparam logic [3:0]          WS_INIT   = 4'(WAIT_STATES);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  slv_state         state, state_nxt;
  logic [3:0]       wcnt, wcnt_nxt;
  logic             wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       strb_q;

  logic [3:0] strb_dec;
  logic       misalign;
  logic       ready;
  logic       active;
  logic       cap;
  logic       err;
  logic       unused_ok;

  ahb_slv_lane_dec u_lane_dec (
    .hsize    (HSIZE),
    .addr_lo  (HADDR[1:0]),
    .strb     (strb_dec),
    .misalign (misalign)
  );

  // Address phase: only sampled while this slave is not stretching a data phase
  assign ready  = (state != ST_WAIT) && (state != ST_ERR1);
  assign active = (HTRANS == NONSEQ) || (HTRANS == SEQ);
  assign cap    = HSEL && HREADY && ready && active;
  assign err    = ({1'b0, HADDR} >= MEM_BYTES) || (HSIZE > WORD) || misalign;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      ST_WAIT: begin
        wcnt_nxt = wcnt - 4'd1;
        if (wcnt == 4'd1) begin
          state_nxt = ST_DATA;
        end
      end
      ST_ERR1: begin
        state_nxt = ST_ERR2;
      end
      default: begin
        // ST_IDLE, ST_DATA and ST_ERR2 all end with HREADYOUT high and may accept a new transfer
        if (!cap) begin
          state_nxt = ST_IDLE;
        end else if (err) begin
          state_nxt = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_DATA;
        end
        if (cap) begin
          wcnt_nxt = WS_INIT;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      wcnt  <= 4'd0;
      wr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (cap) begin
        wr_q <= HWRITE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (cap) begin
      idx_q  <= HADDR[IDX_W+1:2];
      strb_q <= strb_dec;
    end
  end

  // Data phase: writes commit on the completing edge, so a following read sees them
  always_ff @(posedge HCLK) begin
    if ((state == ST_DATA) && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) begin
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HRDATA    = ((state == ST_DATA) && !wr_q) ? mem[idx_q] : '0;
  assign HREADYOUT = ready;
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? ERROR : OKAY;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

endmodule
